// File: rtl/disp_pkg.sv
// Shared definitions for the display command path: state encodings,
// escape byte, power-up table, long-wait opcodes and default tick counts.
package disp_pkg;

   typedef enum logic [2:0] {
      S_POWERUP,
      S_INIT,
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_WRITE
   } ctl_state_t;

   typedef enum logic [2:0] {
      S_WR_IDLE,
      S_SETUP,
      S_EHIGH,
      S_HOLD,
      S_WAIT
   } wr_state_t;

   localparam logic [7:0] ESC_BYTE    = 8'h00;
   localparam logic [7:0] OP_CLEAR    = 8'h01;
   localparam logic [7:0] OP_HOME     = 8'h02;
   localparam logic [7:0] OP_HOME_ALT = 8'h03;

   localparam int INIT_LEN = 4;

   localparam int DEF_E_SETUP_TICKS = 5;
   localparam int DEF_E_HIGH_TICKS  = 29;
   localparam int DEF_WAIT_SHORT    = 4800;
   localparam int DEF_WAIT_LONG     = 196800;
   localparam int DEF_WAIT_POWERUP  = 4800000;
   localparam int DEF_CNT_W         = 24;

   // 8-bit bus, 2 lines; display on; clear; entry mode increment
   function automatic logic [7:0] init_entry(input logic [1:0] idx);
      logic [7:0] v;
      unique case (idx)
         2'd0: v = 8'h38;
         2'd1: v = 8'h0C;
         2'd2: v = 8'h01;
         2'd3: v = 8'h06;
      endcase
      return v;
   endfunction

   // clear and return-home need the long execution delay
   function automatic logic needs_long_wait(input logic rs,
                                            input logic [7:0] db);
      return !rs && (db == OP_CLEAR || db == OP_HOME || db == OP_HOME_ALT);
   endfunction

endpackage

// File: rtl/lcd_write_cycle.sv
// One HD44780 write: setup, E high, hold, then the execution wait.
// Bus outputs are latched on start and held until the next start.
module lcd_write_cycle
   import disp_pkg::*;
#(
   parameter int E_SETUP_TICKS = DEF_E_SETUP_TICKS,
   parameter int E_HIGH_TICKS  = DEF_E_HIGH_TICKS,
   parameter int WAIT_SHORT    = DEF_WAIT_SHORT,
   parameter int WAIT_LONG     = DEF_WAIT_LONG,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       start,
   input  logic       rs,
   input  logic [7:0] db,
   input  logic       long_wait,
   output logic       done,
   output logic       lcd_rs,
   output logic       lcd_e,
   output logic [7:0] lcd_db
);

   wr_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic             long_q;

   assign done = (state == S_WAIT) && (cnt == '0);

   // phase sequencer; every phase loads ticks-1 and leaves at zero
   always_ff @(posedge clk) begin
      if (nrst) begin
         state  <= S_WR_IDLE;
         cnt    <= '0;
         long_q <= 1'b0;
         lcd_rs <= 1'b0;
         lcd_e  <= 1'b0;
         lcd_db <= 8'h00;
      end else begin
         unique case (state)
            S_WR_IDLE: begin
               if (start) begin
                  lcd_rs <= rs;
                  lcd_db <= db;
                  long_q <= long_wait;
                  cnt    <= CNT_W'(E_SETUP_TICKS - 1);
                  state  <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (cnt == '0) begin
                  lcd_e <= 1'b1;
                  cnt   <= CNT_W'(E_HIGH_TICKS - 1);
                  state <= S_EHIGH;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_EHIGH: begin
               if (cnt == '0) begin
                  lcd_e <= 1'b0;
                  cnt   <= CNT_W'(E_SETUP_TICKS - 1);
                  state <= S_HOLD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_HOLD: begin
               if (cnt == '0) begin
                  cnt   <= long_q ? CNT_W'(WAIT_LONG - 1)
                                  : CNT_W'(WAIT_SHORT - 1);
                  state <= S_WAIT;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_WAIT: begin
               if (cnt == '0) state <= S_WR_IDLE;
               else           cnt   <= cnt - 1'b1;
            end
            default: begin
               lcd_e <= 1'b0;
               state <= S_WR_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/display_cmd_exec.sv
// Pops bytes from the shared command register, splits escape-prefixed
// instructions from character data and feeds the LCD write sequencer.
module display_cmd_exec
   import disp_pkg::*;
#(
   parameter int E_SETUP_TICKS = DEF_E_SETUP_TICKS,
   parameter int E_HIGH_TICKS  = DEF_E_HIGH_TICKS,
   parameter int WAIT_SHORT    = DEF_WAIT_SHORT,
   parameter int WAIT_LONG     = DEF_WAIT_LONG,
   parameter int WAIT_POWERUP  = DEF_WAIT_POWERUP,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       cmdreg_data_avail,
   input  logic [7:0] cmdreg_data_recv,
   output logic       cmdreg_rd,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic [7:0] lcd_db,
   output logic       busy,
   output logic       init_done
);

   ctl_state_t       state;
   logic [CNT_W-1:0] pwr_cnt;
   logic [2:0]       init_idx;
   logic [7:0]       byte_q;
   logic             esc_pending;

   logic             wr_start;
   logic             wr_rs;
   logic [7:0]       wr_db;
   logic             wr_long;
   logic             wr_done;

   assign lcd_rw  = 1'b0;
   assign wr_long = needs_long_wait(wr_rs, wr_db);

   // launch a bus write from INIT or from a non-escape DECODE
   always_comb begin
      wr_start = 1'b0;
      wr_rs    = 1'b0;
      wr_db    = 8'h00;
      if (state == S_INIT) begin
         wr_start = 1'b1;
         wr_db    = init_entry(init_idx[1:0]);
      end else if (state == S_DECODE &&
                   (esc_pending || byte_q != ESC_BYTE)) begin
         wr_start = 1'b1;
         wr_rs    = ~esc_pending;
         wr_db    = byte_q;
      end
   end

   // control FSM: power-up delay, init table, fetch and decode
   always_ff @(posedge clk) begin
      if (nrst) begin
         state       <= S_POWERUP;
         pwr_cnt     <= '0;
         init_idx    <= 3'd0;
         byte_q      <= 8'h00;
         esc_pending <= 1'b0;
         cmdreg_rd   <= 1'b0;
         busy        <= 1'b1;
         init_done   <= 1'b0;
      end else begin
         unique case (state)
            S_POWERUP: begin
               if (pwr_cnt == CNT_W'(WAIT_POWERUP - 1)) state <= S_INIT;
               else pwr_cnt <= pwr_cnt + 1'b1;
            end
            S_INIT: begin
               init_idx <= init_idx + 3'd1;
               state    <= S_WRITE;
            end
            S_WRITE: begin
               if (wr_done) begin
                  if (!init_done && init_idx != 3'(INIT_LEN)) begin
                     state <= S_INIT;
                  end else begin
                     init_done <= 1'b1;
                     busy      <= 1'b0;
                     state     <= S_IDLE;
                  end
               end
            end
            S_IDLE: begin
               if (cmdreg_data_avail) begin
                  byte_q    <= cmdreg_data_recv;
                  cmdreg_rd <= 1'b1;
                  busy      <= 1'b1;
                  state     <= S_FETCH;
               end
            end
            S_FETCH: begin
               // avail may still be stale here; it is not looked at
               cmdreg_rd <= 1'b0;
               state     <= S_DECODE;
            end
            S_DECODE: begin
               if (!esc_pending && byte_q == ESC_BYTE) begin
                  esc_pending <= 1'b1;
                  busy        <= 1'b0;
                  state       <= S_IDLE;
               end else begin
                  esc_pending <= 1'b0;
                  state       <= S_WRITE;
               end
            end
            default: state <= S_POWERUP;
         endcase
      end
   end

   lcd_write_cycle #(
      .E_SETUP_TICKS (E_SETUP_TICKS),
      .E_HIGH_TICKS  (E_HIGH_TICKS),
      .WAIT_SHORT    (WAIT_SHORT),
      .WAIT_LONG     (WAIT_LONG),
      .CNT_W         (CNT_W)
   ) u_wr (
      .clk       (clk),
      .nrst      (nrst),
      .start     (wr_start),
      .rs        (wr_rs),
      .db        (wr_db),
      .long_wait (wr_long),
      .done      (wr_done),
      .lcd_rs    (lcd_rs),
      .lcd_e     (lcd_e),
      .lcd_db    (lcd_db)
   );

endmodule

// File: tb/tb_display_cmd_exec.sv
// Bench for display_cmd_exec: random byte stream through a command
// register model, LCD bus checked against an escape-decoding reference.
module tb_display_cmd_exec;

   localparam int ES = 2;
   localparam int EH = 3;
   localparam int WS = 10;
   localparam int WL = 40;
   localparam int PW = 50;

   logic       clk = 1'b0;
   logic       nrst;
   logic       cmdreg_data_avail;
   logic [7:0] cmdreg_data_recv;
   logic       cmdreg_rd;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_e;
   logic [7:0] lcd_db;
   logic       busy;
   logic       init_done;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0] src_q[$];
   logic [8:0] exp_q[$];
   bit         esc_m;
   int         rd_cnt = 0;

   display_cmd_exec #(
      .E_SETUP_TICKS (ES),
      .E_HIGH_TICKS  (EH),
      .WAIT_SHORT    (WS),
      .WAIT_LONG     (WL),
      .WAIT_POWERUP  (PW),
      .CNT_W         (24)
   ) dut (
      .clk               (clk),
      .nrst              (nrst),
      .cmdreg_data_avail (cmdreg_data_avail),
      .cmdreg_data_recv  (cmdreg_data_recv),
      .cmdreg_rd         (cmdreg_rd),
      .lcd_rs            (lcd_rs),
      .lcd_rw            (lcd_rw),
      .lcd_e             (lcd_e),
      .lcd_db            (lcd_db),
      .busy              (busy),
      .init_done         (init_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", tag, got, want);
      end
   endtask

   function automatic bit is_long(input logic [8:0] x);
      return !x[8] && x[7:0] >= 8'h01 && x[7:0] <= 8'h03;
   endfunction

   // reference: ESC prefixes one instruction, ESC ESC is instruction 00
   task automatic send(input logic [7:0] b);
      src_q.push_back(b);
      if (!esc_m && b == 8'h00) begin
         esc_m = 1'b1;
      end else begin
         exp_q.push_back({~esc_m, b});
         esc_m = 1'b0;
      end
   endtask

   task automatic load_init();
      logic [7:0] tbl [4];
      tbl = '{8'h38, 8'h0C, 8'h01, 8'h06};
      exp_q.delete();
      esc_m = 1'b0;
      foreach (tbl[i]) exp_q.push_back({1'b0, tbl[i]});
   endtask

   task automatic wait_init(input int budget);
      int n = 0;
      while (!init_done && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("init_done", init_done, 1);
      chk("idle_after_init", busy, 0);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (!(src_q.size() == 0 && !cmdreg_data_avail &&
               exp_q.size() == 0 && !busy && !lcd_e) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("drain", n < budget, 1);
   endtask

   // shared command register: pop on rd, refill from the source queue
   initial begin
      cmdreg_data_avail = 1'b0;
      cmdreg_data_recv  = 8'h00;
      forever begin
         @(negedge clk);
         if (cmdreg_rd) begin
            if (src_q.size() != 0) begin
               cmdreg_data_recv  = src_q.pop_front();
               cmdreg_data_avail = 1'b1;
            end else begin
               cmdreg_data_avail = 1'b0;
            end
         end else if (!cmdreg_data_avail && src_q.size() != 0) begin
            cmdreg_data_recv  = src_q.pop_front();
            cmdreg_data_avail = 1'b1;
         end
      end
   end

   // bus monitor: content, strobe shape, setup/hold, latency, waits
   initial begin
      int         cyc = 0, rel = 0, stable = 0, high = 0;
      int         fall_c = -1000, rise_c = 0, rd_c = 0, irise = 0;
      bit         pe = 0, prd = 0, pbusy = 1, rose = 0, plong = 0;
      logic [8:0] pbus = '0, bus, ex;
      forever begin
         @(negedge clk);
         cyc++;
         bus = {lcd_rs, lcd_db};
         if (nrst) begin
            rel = 0; fall_c = -1000; irise = 0; rose = 0;
            stable = 0; high = 0;
         end else begin
            rel++;
            if (bus != pbus) begin
               chk("db_hold", !lcd_e && (cyc - fall_c >= ES), 1);
               stable = 0;
            end else begin
               stable++;
            end
            if (cmdreg_rd) chk("rd_width", prd, 0);
            if (cmdreg_rd && !prd) begin
               chk("rd_gate", init_done, 1);
               rd_c = cyc;
               rd_cnt++;
            end
            if (lcd_e && !pe) begin
               if (exp_q.size() == 0) begin
                  chk("e_unexpected", bus, 9'h1FF);
                  ex = bus;
               end else begin
                  ex = exp_q.pop_front();
                  chk("e_bus", bus, ex);
               end
               chk("setup", stable >= ES, 1);
               if (init_done) begin
                  chk("latency", cyc - rd_c, 2 + ES);
               end else begin
                  if (irise == 0) chk("pwr_wait", rel >= PW, 1);
                  else chk("init_gap", cyc - rise_c,
                           EH + 2 * ES + 1 + (plong ? WL : WS));
                  irise++;
               end
               plong  = is_long(ex);
               rise_c = cyc;
               rose   = 1;
               high   = 1;
            end else if (lcd_e) begin
               high++;
            end
            if (!lcd_e && pe) begin
               chk("e_width", high, EH);
               fall_c = cyc;
            end
            if (!busy && pbusy && rose) begin
               chk("wait_len", cyc - rise_c, EH + ES + (plong ? WL : WS));
               rose = 0;
            end
         end
         pe = lcd_e; prd = cmdreg_rd; pbusy = busy; pbus = bus;
      end
   end

   initial begin
      int n0, r, n;
      logic [7:0] b;
      nrst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_rd", cmdreg_rd, 0);
      chk("rst_e", lcd_e, 0);
      chk("rst_rs_db", {lcd_rs, lcd_rw, lcd_db}, 0);
      chk("rst_busy", busy, 1);
      chk("rst_init_done", init_done, 0);
      load_init();
      send(8'h41);
      nrst = 1'b0;
      wait_init(400);
      drain(200);

      send(8'h00); send(8'h01);
      drain(300);
      send(8'h00); send(8'h00); send(8'h42);
      drain(300);

      n0 = rd_cnt;
      for (int i = 0; i < 3; i++) send(8'($urandom_range(1, 255)));
      drain(400);
      chk("rd_count", rd_cnt - n0, 3);

      for (int i = 0; i < 30; i++) begin
         r = $urandom_range(0, 7);
         if (r < 2)       b = 8'h00;
         else if (r == 2) b = 8'($urandom_range(1, 3));
         else             b = 8'($urandom_range(0, 255));
         send(b);
         if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 20)) @(negedge clk);
      end
      drain(4000);

      send(8'h55);
      n = 0;
      while (!lcd_e && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("e_seen", lcd_e, 1);
      nrst = 1'b1;
      @(negedge clk);
      chk("mid_rst_e", lcd_e, 0);
      chk("mid_rst_bus", {cmdreg_rd, lcd_rs, lcd_db}, 0);
      chk("mid_rst_flags", {busy, init_done}, 2'b10);
      load_init();
      @(negedge clk);
      nrst = 1'b0;
      wait_init(400);
      send(8'h00); send(8'h02); send(8'h61);
      drain(400);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
